// File: rtl/apb_traffic_light_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_traffic_light_slave_if
// Brief    : APB bus bundle between the master and the traffic-light slave.
//            PSLVERR exists only when APB_PSLVERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_traffic_light_slave_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
`ifdef APB_PSLVERR_EN
   logic        PSLVERR;
`endif

   modport master (
`ifdef APB_PSLVERR_EN
      input  PSLVERR,
`endif
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
`ifdef APB_PSLVERR_EN
      output PSLVERR,
`endif
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY
   );
endinterface
`default_nettype wire

// File: rtl/apb_traffic_light_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_traffic_light_slave
// Brief    : APB completer with CTRL/duration registers driving a traffic-light
//            FSM. Define APB_PSLVERR_EN to enable PSLVERR on bad accesses.
// Revision : 1.0 - initial release
// ============================================================================
module apb_traffic_light_slave #(
   parameter int TIMER_W     = 16,
   parameter int PRESCALE    = 4,
   parameter int WAIT_STATES = 0,
   parameter int RST_RED     = 8,
   parameter int RST_GREEN   = 8,
   parameter int RST_YELLOW  = 2
) (
   input  wire                       PCLK,
   input  wire                       PRESET,
   apb_traffic_light_slave_if.slave  apb,
   output logic [2:0]                LIGHT
);

   localparam logic [1:0] c_RED    = 2'd0;
   localparam logic [1:0] c_GREEN  = 2'd1;
   localparam logic [1:0] c_YELLOW = 2'd2;
   localparam logic [1:0] c_BLINK  = 2'd3;

   localparam int               c_PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_PW-1:0]  c_PS_LAST = c_PW'(PRESCALE - 1);
   localparam logic [2:0]       c_WS      = 3'(WAIT_STATES);

   logic                w_access;
   logic                w_done;
   logic [2:0]          w_idx;
   logic [31:0]         w_rdata;
   logic [2:0]          r_wait_cnt;
   logic                r_pready;
   logic [31:0]         r_prdata;
   logic [1:0]          r_ctrl;
   logic [TIMER_W-1:0]  r_t_red;
   logic [TIMER_W-1:0]  r_t_green;
   logic [TIMER_W-1:0]  r_t_yellow;

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [TIMER_W-1:0]  r_cnt;
   logic [TIMER_W-1:0]  w_cnt_nxt;
   logic [c_PW-1:0]     r_presc;
   logic [c_PW-1:0]     w_presc_nxt;
   logic                r_blink_on;
   logic                w_blink_on_nxt;
   logic                w_tick;
   logic                w_unused;

   function automatic logic [TIMER_W-1:0] f_eff(input logic [TIMER_W-1:0] d);
      return (d == '0) ? TIMER_W'(1) : d;
   endfunction

   assign w_access = apb.PSEL & apb.PENABLE;
   assign w_idx    = apb.PADDR[4:2];
   // The PREADY cycle itself is never counted, so a held access restarts cleanly.
   assign w_done   = w_access & ~r_pready & (r_wait_cnt == c_WS);
   assign w_unused = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA[31:TIMER_W]};

   always_comb begin
      w_rdata = '0;
      case (w_idx)
         3'd0:    w_rdata = {30'd0, r_ctrl};
         3'd1:    w_rdata = 32'(r_t_red);
         3'd2:    w_rdata = 32'(r_t_green);
         3'd3:    w_rdata = 32'(r_t_yellow);
         3'd4:    w_rdata = 32'({r_cnt, r_state});
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_wait_cnt <= '0;
         r_pready   <= 1'b0;
         r_prdata   <= '0;
      end else begin
         r_pready <= w_done;
         r_prdata <= (w_done && !apb.PWRITE) ? w_rdata : '0;
         if (w_access && !r_pready && !w_done)
            r_wait_cnt <= r_wait_cnt + 3'd1;
         else
            r_wait_cnt <= '0;
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_ctrl     <= '0;
         r_t_red    <= TIMER_W'(RST_RED);
         r_t_green  <= TIMER_W'(RST_GREEN);
         r_t_yellow <= TIMER_W'(RST_YELLOW);
      end else if (w_done && apb.PWRITE) begin
         case (w_idx)
            3'd0:    r_ctrl     <= apb.PWDATA[1:0];
            3'd1:    r_t_red    <= apb.PWDATA[TIMER_W-1:0];
            3'd2:    r_t_green  <= apb.PWDATA[TIMER_W-1:0];
            3'd3:    r_t_yellow <= apb.PWDATA[TIMER_W-1:0];
            default: ;
         endcase
      end
   end

   assign apb.PREADY = r_pready;
   assign apb.PRDATA = r_prdata;

`ifdef APB_PSLVERR_EN
   logic r_pslverr;
   logic w_bad;

   assign w_bad = (w_idx > 3'd4) | (apb.PWRITE & (w_idx == 3'd4));

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET)
         r_pslverr <= 1'b0;
      else
         r_pslverr <= w_done & w_bad;
   end

   assign apb.PSLVERR = r_pslverr;
`else
   // Unmapped and read-only accesses complete with a normal PREADY only.
`endif

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_state    <= c_RED;
         r_cnt      <= '0;
         r_presc    <= '0;
         r_blink_on <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_presc    <= w_presc_nxt;
         r_blink_on <= w_blink_on_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_presc_nxt    = r_presc;
      w_blink_on_nxt = r_blink_on;
      w_tick         = (r_presc == c_PS_LAST);
      if (!r_ctrl[0]) begin
         w_state_nxt    = c_RED;
         w_cnt_nxt      = f_eff(r_t_red);
         w_presc_nxt    = '0;
         w_blink_on_nxt = 1'b0;
      end else if (r_ctrl[1] && (r_state != c_BLINK)) begin
         w_state_nxt    = c_BLINK;
         w_cnt_nxt      = f_eff(r_t_yellow);
         w_presc_nxt    = '0;
         w_blink_on_nxt = 1'b1;
      end else if (!r_ctrl[1] && (r_state == c_BLINK)) begin
         w_state_nxt    = c_RED;
         w_cnt_nxt      = f_eff(r_t_red);
         w_presc_nxt    = '0;
         w_blink_on_nxt = 1'b0;
      end else begin
         w_presc_nxt = w_tick ? '0 : r_presc + c_PW'(1);
         if (w_tick) begin
            if (r_cnt <= TIMER_W'(1)) begin
               case (r_state)
                  c_RED: begin
                     w_state_nxt = c_GREEN;
                     w_cnt_nxt   = f_eff(r_t_green);
                  end
                  c_GREEN: begin
                     w_state_nxt = c_YELLOW;
                     w_cnt_nxt   = f_eff(r_t_yellow);
                  end
                  c_YELLOW: begin
                     w_state_nxt = c_RED;
                     w_cnt_nxt   = f_eff(r_t_red);
                  end
                  default: begin
                     w_blink_on_nxt = ~r_blink_on;
                     w_cnt_nxt      = f_eff(r_t_yellow);
                  end
               endcase
            end else begin
               w_cnt_nxt = r_cnt - TIMER_W'(1);
            end
         end
      end
   end

   always_comb begin
      LIGHT = 3'b000;
      case (r_state)
         c_RED:    LIGHT = 3'b100;
         c_GREEN:  LIGHT = 3'b001;
         c_YELLOW: LIGHT = 3'b010;
         default:  LIGHT = r_blink_on ? 3'b010 : 3'b000;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_traffic_light_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_traffic_light_slave
// Brief    : Directed bench with a phase-level light model; dut0 has no wait
//            states, dut2 has two. APB_PSLVERR_EN adds PSLVERR checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_traffic_light_slave;

   localparam int PRE = 4;

   logic       PCLK;
   logic       rst0_n;
   logic       rst2_n;
   logic [2:0] light0;
   logic [2:0] light2;

   apb_traffic_light_slave_if bus0 ();
   apb_traffic_light_slave_if bus2 ();

   apb_traffic_light_slave #(.WAIT_STATES(0)) dut0 (
      .PCLK(PCLK), .PRESET(rst0_n), .apb(bus0), .LIGHT(light0));
   apb_traffic_light_slave #(.WAIT_STATES(2)) dut2 (
      .PCLK(PCLK), .PRESET(rst2_n), .apb(bus2), .LIGHT(light2));

   int n_pass  = 0;
   int n_total = 0;
   bit run     = 1'b0;

   // Phase-level model of dut0: phase ends are absolute edge numbers.
   int       cyc     = 0;
   logic [1:0] m_ctrl = 2'd0;
   int       m_tr    = 8;
   int       m_tg    = 8;
   int       m_ty    = 2;
   int       m_phase = 0;
   bit       m_on    = 1'b0;
   int       m_end   = 0;
   int       last_commit = 0;

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic logic [2:0] m_light(input int ph, input bit on);
      case (ph)
         0:       return 3'b100;
         1:       return 3'b001;
         2:       return 3'b010;
         default: return on ? 3'b010 : 3'b000;
      endcase
   endfunction

   function automatic int dur_of(input int ph);
      return (ph == 0) ? m_tr : (ph == 1) ? m_tg : m_ty;
   endfunction

   always @(posedge PCLK) begin
      cyc <= cyc + 1;
      if (rst0_n) begin
         if (!m_ctrl[0]) begin
            m_phase <= 0;
            m_on    <= 1'b0;
            m_end   <= cyc + 1 + eff(m_tr) * PRE;
         end else if (m_ctrl[1]) begin
            if (m_phase != 3) begin
               m_phase <= 3;
               m_on    <= 1'b1;
               m_end   <= cyc + 1 + eff(m_ty) * PRE;
            end else if (cyc + 1 == m_end) begin
               m_on  <= !m_on;
               m_end <= cyc + 1 + eff(m_ty) * PRE;
            end
         end else if (m_phase == 3) begin
            m_phase <= 0;
            m_end   <= cyc + 1 + eff(m_tr) * PRE;
         end else if (cyc + 1 == m_end) begin
            m_phase <= (m_phase + 1) % 3;
            m_end   <= cyc + 1 + eff(dur_of((m_phase + 1) % 3)) * PRE;
         end
      end
   end

   always @(negedge PCLK) begin
      if (run && rst0_n) chk("light0_model", 32'(light0), 32'(m_light(m_phase, m_on)));
      if (run) chk("light2_idle", 32'(light2), 32'(3'b100));
   end

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
      case (addr[4:2])
         3'd0: m_ctrl = data[1:0];
         3'd1: m_tr   = int'(data[15:0]);
         3'd2: m_tg   = int'(data[15:0]);
         3'd3: m_ty   = int'(data[15:0]);
         default: ;
      endcase
   endtask

   task automatic w0(input logic [31:0] addr, input logic [31:0] data);
      @(posedge PCLK); #1;
      bus0.PSEL = 1'b1; bus0.PENABLE = 1'b1; bus0.PWRITE = 1'b1;
      bus0.PADDR = addr; bus0.PWDATA = data;
      @(posedge PCLK); #1;
      bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b0;
      last_commit = cyc;
      model_write(addr, data);
      @(negedge PCLK);
      chk("w0_pready", 32'(bus0.PREADY), 32'd1);
   endtask

   task automatic r0(input logic [31:0] addr, input logic [31:0] exp, input string name);
      @(posedge PCLK); #1;
      bus0.PSEL = 1'b1; bus0.PENABLE = 1'b1; bus0.PWRITE = 1'b0; bus0.PADDR = addr;
      @(posedge PCLK); #1;
      bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0;
      @(negedge PCLK);
      chk({name, "_pready"}, 32'(bus0.PREADY), 32'd1);
      chk(name, bus0.PRDATA, exp);
   endtask

   task automatic light_at(input int target, input logic [2:0] exp, input string name);
      while (cyc < target) @(negedge PCLK);
      chk(name, 32'(light0), 32'(exp));
   endtask

   task automatic x2(input logic [31:0] addr, input bit wr, input logic [31:0] data,
                     output logic [31:0] rdata, output int waits, output bit err);
      @(posedge PCLK); #1;
      bus2.PSEL = 1'b1; bus2.PENABLE = 1'b1; bus2.PWRITE = wr;
      bus2.PADDR = addr; bus2.PWDATA = data;
      waits = 0;
      err   = 1'b0;
      @(negedge PCLK);
      while (bus2.PREADY !== 1'b1 && waits < 20) begin
         waits++;
         @(negedge PCLK);
      end
      rdata = bus2.PRDATA;
`ifdef APB_PSLVERR_EN
      err = bus2.PSLVERR;
`endif
      @(posedge PCLK); #1;
      bus2.PSEL = 1'b0; bus2.PENABLE = 1'b0; bus2.PWRITE = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int          wt;
      bit          er;
      int          e;

      rst0_n = 1'b0; rst2_n = 1'b0;
      bus0.PSEL = 0; bus0.PENABLE = 0; bus0.PWRITE = 0; bus0.PADDR = '0; bus0.PWDATA = '0;
      bus2.PSEL = 0; bus2.PENABLE = 0; bus2.PWRITE = 0; bus2.PADDR = '0; bus2.PWDATA = '0;
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_light", 32'(light0), 32'(3'b100));
      chk("rst_pready", 32'(bus0.PREADY), 32'd0);
      chk("rst_prdata", bus0.PRDATA, 32'd0);
      @(posedge PCLK); #1;
      rst0_n = 1'b1; rst2_n = 1'b1; run = 1'b1;

      r0(32'h04, 32'd8, "rst_t_red");
      r0(32'h08, 32'd8, "rst_t_green");
      r0(32'h0C, 32'd2, "rst_t_yellow");
      r0(32'h00, 32'd0, "rst_ctrl");
      r0(32'h10, 32'd32, "rst_status");

      w0(32'h08, 32'd5);
      @(negedge PCLK);
      chk("pready_drop", 32'(bus0.PREADY), 32'd0);
      r0(32'h08, 32'd5, "rb_t_green");
      w0(32'h08, 32'd8);
      w0(32'h1C, 32'd7);
      r0(32'h1C, 32'd0, "unmapped_rd");
      w0(32'h10, 32'hFFFF);
      r0(32'h10, 32'd32, "status_ro");

      // Normal cycle: RED 32, GREEN 32, YELLOW 8 clocks.
      w0(32'h00, 32'd1);
      e = last_commit;
      light_at(e + 31, 3'b100, "red_end");
      light_at(e + 32, 3'b001, "green_start");
      light_at(e + 63, 3'b001, "green_end");
      light_at(e + 64, 3'b010, "yellow_start");
      light_at(e + 71, 3'b010, "yellow_end");
      light_at(e + 72, 3'b100, "red_again");
      w0(32'h08, 32'd3);
      light_at(e + 103, 3'b100, "red2_end");
      light_at(e + 104, 3'b001, "green2_start");
      light_at(e + 115, 3'b001, "green2_short_end");
      light_at(e + 116, 3'b010, "yellow2_start");
      light_at(e + 124, 3'b100, "red3_start");
      w0(32'h08, 32'd8);

      w0(32'h00, 32'd3);
      e = last_commit;
      light_at(e + 1, 3'b010, "blink_on0");
      light_at(e + 8, 3'b010, "blink_on_end");
      light_at(e + 9, 3'b000, "blink_off0");
      light_at(e + 16, 3'b000, "blink_off_end");
      light_at(e + 17, 3'b010, "blink_on1");

      w0(32'h00, 32'd1);
      e = last_commit;
      light_at(e + 32, 3'b100, "unblink_red_end");
      light_at(e + 33, 3'b001, "unblink_green");

      w0(32'h00, 32'd0);
      e = last_commit;
      light_at(e + 1, 3'b100, "disable_red");
      r0(32'h10, 32'd32, "status_disabled");

      w0(32'h04, 32'd0);
      w0(32'h00, 32'd1);
      e = last_commit;
      light_at(e + 3, 3'b100, "zero_red");
      light_at(e + 4, 3'b001, "zero_red_to_green");
      w0(32'h00, 32'd0);
      w0(32'h04, 32'd8);
      r0(32'h04, 32'd8, "t_red_restored");

      // Two wait states on dut2.
      x2(32'h04, 1'b0, 32'd0, rd, wt, er);
      chk("ws2_latency", 32'(wt), 32'd3);
      chk("ws2_prdata", rd, 32'd8);
      @(negedge PCLK);
      chk("ws2_pready_drop", 32'(bus2.PREADY), 32'd0);
      chk("ws2_prdata_clear", bus2.PRDATA, 32'd0);

      @(posedge PCLK); #1;
      bus2.PSEL = 1'b1; bus2.PENABLE = 1'b1; bus2.PWRITE = 1'b1;
      bus2.PADDR = 32'h08; bus2.PWDATA = 32'd9;
      repeat (2) @(posedge PCLK);
      #1;
      bus2.PSEL = 1'b0; bus2.PENABLE = 1'b0; bus2.PWRITE = 1'b0;
      x2(32'h08, 1'b0, 32'd0, rd, wt, er);
      chk("abort_no_commit", rd, 32'd8);

      x2(32'h08, 1'b1, 32'd6, rd, wt, er);
      x2(32'h08, 1'b0, 32'd0, rd, wt, er);
      chk("ws2_write_rb", rd, 32'd6);
      x2(32'h1C, 1'b0, 32'd0, rd, wt, er);
      chk("ws2_unmapped_rd", rd, 32'd0);
`ifdef APB_PSLVERR_EN
      chk("pslverr_unmapped", 32'(er), 32'd1);
      x2(32'h04, 1'b0, 32'd0, rd, wt, er);
      chk("pslverr_ok", 32'(er), 32'd0);
`endif
      x2(32'h10, 1'b1, 32'd5, rd, wt, er);
`ifdef APB_PSLVERR_EN
      chk("pslverr_status_wr", 32'(er), 32'd1);
`endif
      x2(32'h10, 1'b0, 32'd0, rd, wt, er);
      chk("ws2_status", rd, 32'd32);

      // Reset during the PREADY cycle clears outputs at once.
      @(posedge PCLK); #1;
      bus2.PSEL = 1'b1; bus2.PENABLE = 1'b1; bus2.PWRITE = 1'b0; bus2.PADDR = 32'h0C;
      wt = 0;
      @(negedge PCLK);
      while (bus2.PREADY !== 1'b1 && wt < 20) begin
         wt++;
         @(negedge PCLK);
      end
      chk("rst_mid_prdata_before", bus2.PRDATA, 32'd2);
      rst2_n = 1'b0;
      #1;
      chk("rst_mid_pready", 32'(bus2.PREADY), 32'd0);
      chk("rst_mid_prdata", bus2.PRDATA, 32'd0);
      @(posedge PCLK); #1;
      bus2.PSEL = 1'b0; bus2.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      rst2_n = 1'b1;
      x2(32'h08, 1'b0, 32'd0, rd, wt, er);
      chk("rst_restores_t_green", rd, 32'd8);

      run = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
